// File: rtl/dot_row_scanner.sv
// Self-timed LED matrix row scanner: drives each row for DWELL cycles with a
// BLANK-cycle all-off gap between rows, and pulses load/frame_start for the column side.
module dot_row_scanner #(
   parameter int ROWS       = 8,
   parameter int ROW_W      = 3,
   parameter int DWELL      = 1024,
   parameter int BLANK      = 16,
   parameter int ACTIVE_LOW = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [ROW_W-1:0] row_sel,
   output logic [ROWS-1:0]  row_q,
   output logic             blank,
   output logic             load,
   output logic             frame_start
);

   localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0]    BLANK_LAST = TW'(BLANK - 1);
   localparam logic [TW-1:0]    DWELL_LAST = TW'(DWELL - 1);
   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [ROWS-1:0]  ROWS_OFF   = {ROWS{(ACTIVE_LOW != 0)}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } state_t;

   state_t           state_q;
   logic [TW-1:0]    timer_q;
   logic [ROW_W-1:0] sel_q;
   logic [ROWS-1:0]  drive_q;
   logic             blank_q;
   logic             load_q;
   logic             fs_q;

   logic [ROW_W-1:0] sel_d;
   logic [ROWS-1:0]  drive_d;

   // Explicit wrap keeps row_sel inside 0..ROWS-1 for non-power-of-2 ROWS.
   always_comb begin
      sel_d   = (sel_q == LAST_ROW) ? '0 : sel_q + ROW_W'(1);
      drive_d = ROWS_OFF ^ (ROWS'(1) << sel_q);
   end

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         sel_q   <= '0;
         drive_q <= ROWS_OFF;
         blank_q <= 1'b1;
         load_q  <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_BLANK;
               timer_q <= '0;
               drive_q <= ROWS_OFF;
               blank_q <= 1'b1;
               load_q  <= 1'b1;
               fs_q    <= 1'b0;
            end
            ST_BLANK: begin
               load_q <= 1'b0;
               if (timer_q == BLANK_LAST) begin
                  state_q <= ST_ON;
                  timer_q <= '0;
                  drive_q <= drive_d;
                  blank_q <= 1'b0;
                  fs_q    <= (sel_q == '0);
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            ST_ON: begin
               fs_q <= 1'b0;
               // Row switch goes through blank in the same edge, so two rows never overlap.
               if (timer_q == DWELL_LAST) begin
                  state_q <= ST_BLANK;
                  timer_q <= '0;
                  sel_q   <= sel_d;
                  drive_q <= ROWS_OFF;
                  blank_q <= 1'b1;
                  load_q  <= 1'b1;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               timer_q <= '0;
               sel_q   <= '0;
               drive_q <= ROWS_OFF;
               blank_q <= 1'b1;
               load_q  <= 1'b0;
               fs_q    <= 1'b0;
            end
         endcase
      end
   end

   assign row_sel     = sel_q;
   assign row_q       = drive_q;
   assign blank       = blank_q;
   assign load        = load_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_dot_row_scanner.sv
// Bench for dot_row_scanner: an 8-row active-high instance and a 5-row active-low
// instance, both DWELL=4 BLANK=2, sharing clock, reset and enable.
module tb_dot_row_scanner;

   localparam int D = 4;
   localparam int B = 2;
   localparam int P = D + B;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b0;

   logic [2:0] sel_a, sel_b;
   logic [7:0] rq_a;
   logic [4:0] rq_b;
   logic       bl_a, ld_a, fs_a, bl_b, ld_b, fs_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dot_row_scanner #(.ROWS(8), .ROW_W(3), .DWELL(D), .BLANK(B), .ACTIVE_LOW(0)) dut_a (
      .clk(clk), .reset(reset), .en(en),
      .row_sel(sel_a), .row_q(rq_a), .blank(bl_a), .load(ld_a), .frame_start(fs_a)
   );

   dot_row_scanner #(.ROWS(5), .ROW_W(3), .DWELL(D), .BLANK(B), .ACTIVE_LOW(1)) dut_b (
      .clk(clk), .reset(reset), .en(en),
      .row_sel(sel_b), .row_q(rq_b), .blank(bl_b), .load(ld_b), .frame_start(fs_b)
   );

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] rq;
      logic       bl;
      logic       ld;
      logic       fs;
   } obs_t;

   typedef struct packed {
      logic rst;
      logic en;
      obs_t exp;
   } vec_t;

   function automatic obs_t mk(int sel, logic [7:0] rq, logic bl, logic ld, logic fs);
      obs_t o;
      o.sel = sel[2:0];
      o.rq  = rq;
      o.bl  = bl;
      o.ld  = ld;
      o.fs  = fs;
      return o;
   endfunction

   // Expected outputs k edges after the enabling edge (k=1 is the first load cycle).
   function automatic obs_t model(int k, int rows, bit al);
      int   p;
      int   r;
      logic [7:0] one;
      logic [7:0] mask;
      obs_t o;
      p    = (k - 1) % P;
      r    = ((k - 1) / P) % rows;
      one  = 8'h01;
      mask = 8'((1 << rows) - 1);
      o.sel = r[2:0];
      o.bl  = (p < B);
      o.ld  = (p == 0);
      o.fs  = (p == B) && (r == 0);
      o.rq  = o.bl ? 8'h00 : (one << r);
      if (al) o.rq = ~o.rq & mask;
      return o;
   endfunction

   function automatic obs_t idle_obs(bit al, int rows);
      logic [7:0] mask;
      mask = 8'((1 << rows) - 1);
      return mk(0, al ? mask : 8'h00, 1'b1, 1'b0, 1'b0);
   endfunction

   function automatic obs_t obs_a();
      return mk(int'(sel_a), rq_a, bl_a, ld_a, fs_a);
   endfunction

   function automatic obs_t obs_b();
      return mk(int'(sel_b), {3'b000, rq_b}, bl_b, ld_b, fs_b);
   endfunction

   task automatic chk(string name, obs_t act, obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got sel=%0d row_q=%h blank=%b load=%b fs=%b, want sel=%0d row_q=%h blank=%b load=%b fs=%b",
                  name, act.sel, act.rq, act.bl, act.ld, act.fs,
                  exp.sel, exp.rq, exp.bl, exp.ld, exp.fs);
      end else begin
         $display("ok %s: sel=%0d row_q=%h blank=%b load=%b fs=%b",
                  name, act.sel, act.rq, act.bl, act.ld, act.fs);
      end
   endtask

   task automatic chk_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end else begin
         $display("ok %s: %0d", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance one edge in the running scan and compare both instances against the model.
   task automatic run_step(inout int k, input string tag);
      tick();
      k++;
      chk($sformatf("%s_a k=%0d", tag, k), obs_a(), model(k, 8, 1'b0));
      chk($sformatf("%s_b k=%0d", tag, k), obs_b(), model(k, 5, 1'b1));
      chk_int($sformatf("%s_onehot_a k=%0d", tag, k), ($countones(rq_a) <= 1) ? 1 : 0, 1);
      chk_int($sformatf("%s_onehot_b k=%0d", tag, k), ($countones(~rq_b) <= 1) ? 1 : 0, 1);
   endtask

   vec_t tbl [13];

   initial begin
      int k;
      int loads;
      int fss;
      int last_fs;
      int fs_gap_bad;

      // Reset with en high, idle, then enable at vector 4 (edge t) and follow through row 1.
      tbl[0]  = '{1'b1, 1'b1, mk(0, 8'h00, 1'b1, 1'b0, 1'b0)};
      tbl[1]  = '{1'b1, 1'b1, mk(0, 8'h00, 1'b1, 1'b0, 1'b0)};
      tbl[2]  = '{1'b1, 1'b1, mk(0, 8'h00, 1'b1, 1'b0, 1'b0)};
      tbl[3]  = '{1'b0, 1'b0, mk(0, 8'h00, 1'b1, 1'b0, 1'b0)};
      tbl[4]  = '{1'b0, 1'b1, mk(0, 8'h00, 1'b1, 1'b1, 1'b0)};
      tbl[5]  = '{1'b0, 1'b1, mk(0, 8'h00, 1'b1, 1'b0, 1'b0)};
      tbl[6]  = '{1'b0, 1'b1, mk(0, 8'h01, 1'b0, 1'b0, 1'b1)};
      tbl[7]  = '{1'b0, 1'b1, mk(0, 8'h01, 1'b0, 1'b0, 1'b0)};
      tbl[8]  = '{1'b0, 1'b1, mk(0, 8'h01, 1'b0, 1'b0, 1'b0)};
      tbl[9]  = '{1'b0, 1'b1, mk(0, 8'h01, 1'b0, 1'b0, 1'b0)};
      tbl[10] = '{1'b0, 1'b1, mk(1, 8'h00, 1'b1, 1'b1, 1'b0)};
      tbl[11] = '{1'b0, 1'b1, mk(1, 8'h00, 1'b1, 1'b0, 1'b0)};
      tbl[12] = '{1'b0, 1'b1, mk(1, 8'h02, 1'b0, 1'b0, 1'b0)};

      reset = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 13; i++) begin
         reset = tbl[i].rst;
         en    = tbl[i].en;
         tick();
         chk($sformatf("vec%0d_a", i), obs_a(), tbl[i].exp);
         if (i < 4) chk($sformatf("vec%0d_b", i), obs_b(), idle_obs(1'b1, 5));
      end

      // Two full frames of the 8-row scan, continuing from k=9.
      k          = 9;
      loads      = 0;
      fss        = 0;
      last_fs    = -1;
      fs_gap_bad = 0;
      for (int i = 0; i < 2 * 8 * P; i++) begin
         run_step(k, "frame");
         if (ld_a) loads++;
         if (fs_a) begin
            if (last_fs >= 0 && (k - last_fs) != 8 * P) fs_gap_bad++;
            last_fs = k;
            fss++;
         end
      end
      chk_int("loads_in_2_frames", loads, 16);
      chk_int("frame_starts_in_2_frames", fss, 2);
      chk_int("frame_start_spacing_errors", fs_gap_bad, 0);

      // Walk to the second ON cycle of row 5, then drop enable.
      while (((k - 1) % (8 * P)) != 5 * P + B + 1) run_step(k, "seek5");
      chk_int("row5_on_before_drop", int'(sel_a), 5);
      en = 1'b0;
      tick();
      chk("drop_en_a", obs_a(), idle_obs(1'b0, 8));
      chk("drop_en_b", obs_b(), idle_obs(1'b1, 5));
      tick();
      chk("drop_en_hold_a", obs_a(), idle_obs(1'b0, 8));

      // Re-enable restarts from row 0 with frame_start; stop in first BLANK cycle of row 3.
      en = 1'b1;
      k  = 0;
      while (k < 3 * P + 1) run_step(k, "restart");

      // Synchronous reset mid-BLANK of row 3.
      chk_int("row3_blank_before_reset", {29'd0, sel_a} + (bl_a ? 100 : 0), 103);
      reset = 1'b1;
      tick();
      chk("reset_midblank_a", obs_a(), idle_obs(1'b0, 8));
      chk("reset_midblank_b", obs_b(), idle_obs(1'b1, 5));
      tick();
      chk("reset_hold_a", obs_a(), idle_obs(1'b0, 8));
      chk("reset_hold_b", obs_b(), idle_obs(1'b1, 5));

      // Release with en high: the releasing edge starts the scan.
      reset = 1'b0;
      k     = 0;
      for (int i = 0; i < 2 * P; i++) run_step(k, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
